// File: rtl/seg7_scan8.sv
// seg7_scan8: time-multiplexed scanner for an 8-digit common-anode display.
// Holds a double-buffered 32-bit value and cycles through the digits. Each
// slot drives the digit's nibble to an external hex7seg decoder, together with
// active-low anode and decimal-point lines. Every slot opens with a short
// all-anodes-off window to suppress ghosting.
module seg7_scan8 #(
  parameter int unsigned DIV       = 12500,
  parameter int unsigned BLANK_CYC = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] data_in,
  input  logic        load,
  input  logic [7:0]  dp_in,
  input  logic [7:0]  digit_en,
  input  logic        lz_blank,
  output logic [3:0]  nibble_out,
  output logic [7:0]  an,
  output logic        dp_n,
  output logic        frame_done
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  typedef logic [CW-1:0] cnt_t;
  localparam cnt_t CNT_MAX = cnt_t'(DIV - 1);
  localparam cnt_t BLANK   = cnt_t'(BLANK_CYC);

  // Scan state
  cnt_t        r_cnt;
  logic [2:0]  r_idx;

  // Double buffer
  logic [31:0] r_shadow_val;
  logic [7:0]  r_shadow_dp;
  logic        r_pend;
  logic [31:0] r_active_val;
  logic [7:0]  r_active_dp;

  // Registered outputs
  logic [3:0]  r_nibble;
  logic [7:0]  r_an;
  logic        r_dp_n;
  logic        r_frame_done;

  // Next-state / combinational
  logic        w_tick;
  logic        w_boundary;
  cnt_t        w_cnt_next;
  logic [2:0]  w_idx_next;
  logic [31:0] w_active_val_next;
  logic [7:0]  w_active_dp_next;
  logic [2:0]  w_msd;
  logic        w_vis;
  logic [7:0]  w_an_next;
  logic        w_dp_n_next;
  logic [3:0]  w_nibble_next;

  // Prescaler and digit index advance
  always_comb begin
    w_tick     = (r_cnt == CNT_MAX);
    w_boundary = w_tick && (r_idx == 3'd7);
    w_cnt_next = w_tick ? '0 : r_cnt + cnt_t'(1);
    w_idx_next = w_tick ? r_idx + 3'd1 : r_idx;
  end

  // Active value swaps only on a frame boundary; a load on the boundary
  // cycle bypasses the shadow so the newest value always wins.
  always_comb begin
    w_active_val_next = r_active_val;
    w_active_dp_next  = r_active_dp;
    if (w_boundary) begin
      if (load) begin
        w_active_val_next = data_in;
        w_active_dp_next  = dp_in;
      end else if (r_pend) begin
        w_active_val_next = r_shadow_val;
        w_active_dp_next  = r_shadow_dp;
      end
    end
  end

  // Most significant non-zero digit of the value about to be displayed
  always_comb begin
    w_msd = '0;
    for (int unsigned k = 1; k < 8; k++) begin
      if (w_active_val_next[4*k +: 4] != 4'h0) begin
        w_msd = 3'(k);
      end
    end
  end

  // Output decode from next-state so outputs line up with the scan state
  always_comb begin
    w_nibble_next = w_active_val_next[4*w_idx_next +: 4];
    w_vis         = digit_en[w_idx_next] && !(lz_blank && (w_idx_next > w_msd));
    w_an_next     = '1;
    if (w_vis && (w_cnt_next >= BLANK)) begin
      w_an_next[w_idx_next] = 1'b0;
    end
    w_dp_n_next = ~(w_active_dp_next[w_idx_next] && !w_an_next[w_idx_next]);
  end

  // Scan counter and digit index registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else begin
      r_cnt <= w_cnt_next;
      r_idx <= w_idx_next;
    end
  end

  // Shadow capture and pending flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow_val <= '0;
      r_shadow_dp  <= '0;
      r_pend       <= 1'b0;
    end else begin
      if (load) begin
        r_shadow_val <= data_in;
        r_shadow_dp  <= dp_in;
      end
      if (w_boundary) begin
        r_pend <= 1'b0;
      end else if (load) begin
        r_pend <= 1'b1;
      end
    end
  end

  // Active (displayed) value registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active_val <= '0;
      r_active_dp  <= '0;
    end else begin
      r_active_val <= w_active_val_next;
      r_active_dp  <= w_active_dp_next;
    end
  end

  // Output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_nibble     <= '0;
      r_an         <= '1;
      r_dp_n       <= 1'b1;
      r_frame_done <= 1'b0;
    end else begin
      r_nibble     <= w_nibble_next;
      r_an         <= w_an_next;
      r_dp_n       <= w_dp_n_next;
      r_frame_done <= w_boundary;
    end
  end

  assign nibble_out = r_nibble;
  assign an         = r_an;
  assign dp_n       = r_dp_n;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg7_scan8.sv
// Directed and randomised checks for seg7_scan8 with DIV=4, BLANK_CYC=1
// (4-cycle slots, 32-cycle frames).
module tb_seg7_scan8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] data_in = '0;
  logic        load = 1'b0;
  logic [7:0]  dp_in = '0;
  logic [7:0]  digit_en = '1;
  logic        lz_blank = 1'b0;
  logic [3:0]  nibble_out;
  logic [7:0]  an;
  logic        dp_n;
  logic        frame_done;

  seg7_scan8 #(.DIV(4), .BLANK_CYC(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_in    (data_in),
    .load       (load),
    .dp_in      (dp_in),
    .digit_en   (digit_en),
    .lz_blank   (lz_blank),
    .nibble_out (nibble_out),
    .an         (an),
    .dp_n       (dp_n),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // k = number of active clock edges since reset release
  int unsigned k = 0;

  // Behavioural model of the buffering, used by the random phase
  logic [31:0] m_act, m_sh;
  logic [7:0]  m_actdp, m_shdp;
  logic        m_pend;

  typedef struct {
    int unsigned cyc;
    logic [7:0]  en;
    logic        lz;
    logic [3:0]  nib;
    logic [7:0]  an;
    logic        dpn;
    logic        fd;
  } vec_t;

  vec_t tbl[$];

  logic [3:0] nib_b [8] = '{4'h0, 4'h2, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
  logic [7:0] an_b  [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %0h expected %0h", nm, k, act, exp);
    end
  endtask

  task automatic model_clear();
    m_act = '0; m_sh = '0; m_actdp = '0; m_shdp = '0; m_pend = 1'b0; k = 0;
  endtask

  // One clock edge; outputs sampled 1 time unit later; load is a 1-cycle strobe
  task automatic step();
    logic        ld;
    logic [31:0] d;
    logic [7:0]  dp;
    ld = load; d = data_in; dp = dp_in;
    @(posedge clk);
    #1;
    if (k % 32 == 31) begin
      if (ld) begin
        m_act = d; m_actdp = dp;
      end else if (m_pend) begin
        m_act = m_sh; m_actdp = m_shdp;
      end
      m_pend = 1'b0;
    end else if (ld) begin
      m_sh = d; m_shdp = dp; m_pend = 1'b1;
    end
    k++;
    load = 1'b0;
  endtask

  task automatic run_to(input int unsigned t);
    while (k < t) step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    load  = 1'b0;
    #12;
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
  endtask

  function automatic int unsigned msd_of(input logic [31:0] v);
    int unsigned m = 0;
    for (int unsigned j = 1; j < 8; j++)
      if (v[4*j +: 4] != 4'h0) m = j;
    return m;
  endfunction

  function automatic logic [7:0] exp_an();
    int unsigned idx = (k / 4) % 8;
    int unsigned cnt = k % 4;
    logic vis;
    logic [7:0] r;
    vis = digit_en[idx] && !(lz_blank && idx > msd_of(m_act));
    r = 8'hFF;
    if (vis && cnt >= 1) r[idx] = 1'b0;
    return r;
  endfunction

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---------------- Phase A: table-driven basic scan ----------------
    tbl.push_back('{1,  8'hFF, 1'b1, 4'h0, 8'hFE, 1'b1, 1'b0});
    tbl.push_back('{2,  8'hFF, 1'b0, 4'h0, 8'hFE, 1'b1, 1'b0});
    tbl.push_back('{4,  8'hFF, 1'b0, 4'h0, 8'hFF, 1'b1, 1'b0});
    tbl.push_back('{5,  8'hFF, 1'b0, 4'h0, 8'hFD, 1'b1, 1'b0});
    tbl.push_back('{6,  8'hFF, 1'b1, 4'h0, 8'hFF, 1'b1, 1'b0});
    tbl.push_back('{29, 8'hFF, 1'b0, 4'h0, 8'h7F, 1'b1, 1'b0});
    tbl.push_back('{31, 8'hFF, 1'b0, 4'h0, 8'h7F, 1'b1, 1'b0});
    tbl.push_back('{32, 8'hFF, 1'b0, 4'hF, 8'hFF, 1'b1, 1'b1});
    tbl.push_back('{33, 8'hFF, 1'b0, 4'hF, 8'hFE, 1'b0, 1'b0});
    tbl.push_back('{37, 8'hFF, 1'b0, 4'hE, 8'hFD, 1'b1, 1'b0});
    tbl.push_back('{45, 8'hFF, 1'b0, 4'hC, 8'hF7, 1'b1, 1'b0});
    tbl.push_back('{61, 8'hFF, 1'b0, 4'h8, 8'h7F, 1'b0, 1'b0});
    tbl.push_back('{63, 8'hFF, 1'b1, 4'h8, 8'h7F, 1'b0, 1'b0});
    tbl.push_back('{64, 8'hFF, 1'b1, 4'hF, 8'hFF, 1'b1, 1'b1});
    tbl.push_back('{65, 8'hFE, 1'b1, 4'hF, 8'hFF, 1'b1, 1'b0});

    digit_en = 8'hFF; lz_blank = 1'b1; dp_in = 8'h00;
    do_reset();
    chk("reset nibble", nibble_out, 0);
    chk("reset an", an, 8'hFF);
    chk("reset dp_n", dp_n, 1);
    chk("reset frame_done", frame_done, 0);

    data_in = 32'h89ABCDEF; dp_in = 8'h81; load = 1'b1;
    foreach (tbl[i]) begin
      while (k + 1 < tbl[i].cyc) step();
      digit_en = tbl[i].en;
      lz_blank = tbl[i].lz;
      step();
      chk("tbl nibble", nibble_out, tbl[i].nib);
      chk("tbl an", an, tbl[i].an);
      chk("tbl dp_n", dp_n, tbl[i].dpn);
      chk("tbl frame_done", frame_done, tbl[i].fd);
    end

    // ---------------- Phase B: leading-zero blanking ----------------
    digit_en = 8'hFF; lz_blank = 1'b1; dp_in = 8'h00;
    do_reset();
    data_in = 32'h00000120; load = 1'b1;
    for (int unsigned d = 0; d < 8; d++) begin
      run_to(32 + 4*d);
      chk("lz blank window", an, 8'hFF);
      step();
      chk("lz nibble", nibble_out, nib_b[d]);
      chk("lz an", an, an_b[d]);
      if (d == 3) begin
        data_in = 32'h0; load = 1'b1;
      end
    end
    for (int unsigned d = 0; d < 8; d++) begin
      run_to(64 + 4*d + 1);
      chk("zero value an", an, (d == 0) ? 8'hFE : 8'hFF);
    end

    // ---------------- Phase C: double buffering / no tearing ----------------
    lz_blank = 1'b0;
    do_reset();
    for (int unsigned t = 1; t < 128; t++) begin
      if (k == 0)  begin data_in = 32'h11111111; load = 1'b1; end
      if (k == 9)  begin data_in = 32'h22222222; load = 1'b1; end
      if (k == 49) begin data_in = 32'h44444444; load = 1'b1; end
      if (k == 63) begin data_in = 32'h33333333; load = 1'b1; end
      step();
      chk("buffer nibble", nibble_out, (k < 32) ? 0 : (k < 64) ? 2 : 3);
    end

    // ---------------- Phase D: digit mask and decimal points ----------------
    digit_en = 8'b1010_0101; dp_in = 8'hFF; lz_blank = 1'b0;
    do_reset();
    data_in = 32'h12345678; load = 1'b1;
    for (int unsigned t = 1; t < 72; t++) begin
      logic [7:0] ea;
      int unsigned idx;
      step();
      idx = (k / 4) % 8;
      ea = ((k % 4) != 0 && digit_en[idx]) ? ~(8'b1 << idx) : 8'hFF;
      chk("mask an", an, ea);
      chk("mask dp_n", dp_n, !(k >= 32 && ea != 8'hFF));
    end

    // ---------------- Phase E: reset mid-slot ----------------
    digit_en = 8'hFF; dp_in = 8'h00;
    do_reset();
    data_in = 32'hCAFEF00D; load = 1'b1;
    run_to(54);
    chk("pre-reset an", an, 8'hDF);
    chk("pre-reset nibble", nibble_out, 4'hF);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset an", an, 8'hFF);
    chk("async reset dp_n", dp_n, 1);
    chk("async reset nibble", nibble_out, 0);
    chk("async reset frame_done", frame_done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    step();
    chk("restart an", an, 8'hFE);
    chk("restart nibble", nibble_out, 0);
    run_to(33);
    chk("restart value cleared nibble", nibble_out, 0);
    chk("restart value cleared an", an, 8'hFE);

    // ---------------- Phase F: random loads and masks ----------------
    do_reset();
    for (int unsigned i = 0; i < 10000; i++) begin
      int unsigned idx;
      logic [7:0] ea;
      load    = ($urandom_range(0, 15) == 0);
      data_in = $urandom >> $urandom_range(0, 31);
      dp_in   = 8'($urandom);
      if ($urandom_range(0, 63) == 0) digit_en = 8'($urandom);
      if ($urandom_range(0, 127) == 0) lz_blank = ~lz_blank;
      step();
      idx = (k / 4) % 8;
      ea  = exp_an();
      chk("rand one-hot", ($countones(~an) <= 1), 1);
      chk("rand an", an, ea);
      chk("rand nibble", nibble_out, m_act[4*idx +: 4]);
      chk("rand dp_n", dp_n, !(m_actdp[idx] && !ea[idx]));
      chk("rand frame_done", frame_done, (k % 32) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
